ctr_sequencer: RTL and testbench
================================

Name: ctr_sequencer

Overview:
Control sequencer for the free-running LED counter datapath on the eFPGA user design. It owns the counter and adds a command port (start/stop/clear/load-limit), a prescaler, a gate from the external enable pin and terminal-count detection in one-shot or periodic mode. It replaces the bare enable-gated counter between the io_in control pins and the io_out LED bank.

Parameters:
CTR_W, 32, counter and limit width
PRESC_W, 16, prescaler divider width
OUT_W, 22, number of LED bits driven from count[OUT_W-1:0]

Ports:
clk  input  1  single system clock, all logic on posedge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command request
cmd_ready  output  1  command accept; transfer when cmd_valid && cmd_ready
cmd_op  input  2  0=START, 1=STOP, 2=CLEAR, 3=LOAD_LIMIT
cmd_data  input  CTR_W  limit value for LOAD_LIMIT, ignored otherwise
mode_periodic  input  1  1=wrap at limit, 0=one-shot; sampled at each terminal tick
presc_div  input  PRESC_W  tick every presc_div+1 enabled cycles
ext_en  input  1  count gate, equivalent of the enable pin
count  output  CTR_W  current counter value
led_out  output  OUT_W  count[OUT_W-1:0]
state  output  2  0=IDLE, 1=RUN, 2=PAUSE, 3=DONE
done  output  1  one-cycle pulse on terminal count
cmd_err  output  1  one-cycle pulse when an accepted command is rejected

Behaviour:
- Reset (async, rst_n low): state=IDLE, count=0, limit=all-ones, presc_cnt=0, done=0, cmd_err=0, cmd_ready=1. All outputs are registered.
- cmd_ready: drops to 0 for exactly the one cycle after any accepted command, then returns to 1. Commands are not queued.
- START: IDLE/PAUSE->RUN. From DONE: count<=0, presc_cnt<=0, ->RUN. In RUN: ignored, no error.
- STOP: RUN->PAUSE; count and presc_cnt hold. Any other state: ignored, no error.
- CLEAR: from any state, count<=0, presc_cnt<=0, state<=IDLE; limit is unchanged.
- LOAD_LIMIT: in IDLE/PAUSE/DONE, limit<=cmd_data. In RUN: rejected, limit unchanged, cmd_err pulses the next cycle.
- Prescaler (RUN only):
  - ext_en=0: presc_cnt holds, no tick.
  - ext_en=1: if presc_cnt==presc_div, tick and presc_cnt<=0; else presc_cnt+1.
  - presc_div=0 ticks every enabled cycle.
- Tick, count!=limit: count<=count+1 (visible next cycle).
- Tick, count==limit: done pulses next cycle, and
  - mode_periodic=1: count<=0, stay RUN.
  - mode_periodic=0: count holds at limit, ->DONE.
- limit=0:
  - periodic: done on every tick, count stays 0.
  - one-shot: first tick ->DONE.
- limit below current count (loaded while paused): counting continues through the CTR_W wrap, 2^CTR_W-1 -> 0, until count==limit.
- Same-cycle command and tick:
  - Accepted STOP or CLEAR wins; the tick is discarded.
  - START in RUN and rejected LOAD_LIMIT do not block the tick.
- IDLE/PAUSE/DONE: count and presc_cnt never change except via CLEAR/START.
- Reset asserted mid-count forces reset values immediately; no done pulse.

Decomposition:
- Shared package ctr_seq_pkg holds:
  - state encoding constants ST_IDLE/ST_RUN/ST_PAUSE/ST_DONE
  - opcode constants OP_START/OP_STOP/OP_CLEAR/OP_LOAD
- Sub-module ctr_prescaler (presc_cnt, ext_en gating, tick output, sync clear input).
- FSM, counter and limit compare stay in ctr_sequencer.
- Top-level wiring maps io_in pins onto cmd/ext_en and led_out onto io_out.

Test Plan:
- Reset, then LOAD_LIMIT 5, START, presc_div=0, ext_en=1, one-shot -> count 0..5 on consecutive cycles, one done pulse, state=DONE, count holds 5.
- Periodic, limit=3, presc_div=2 -> count increments every 3rd cycle, sequence 0,1,2,3,0,...; done pulse every 12 cycles.
- RUN with ext_en toggling 1/0 each cycle, presc_div=0 -> count advances every other cycle; STOP -> PAUSE with count frozen; START resumes from the held value.
- LOAD_LIMIT while RUN -> cmd_err pulse, limit unchanged. STOP issued on a tick cycle -> no increment. cmd_ready low exactly one cycle after each accept.
- CLEAR from DONE with count=5 -> count=0, state=IDLE. START from DONE -> count restarts at 0.
- Assert rst_n low asynchronously mid-RUN at count=1000 -> all outputs return to reset values before the next clk edge; no done pulse.

Source files
------------

// File: rtl/ctr_seq_pkg.sv
// Shared types and defaults for the LED counter control sequencer.
package ctr_seq_pkg;

  localparam int CTR_W_DEF   = 32;
  localparam int PRESC_W_DEF = 16;
  localparam int OUT_W_DEF   = 22;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_START = 2'd0,
    OP_STOP  = 2'd1,
    OP_CLEAR = 2'd2,
    OP_LOAD  = 2'd3
  } op_t;

  // STOP and CLEAR take precedence over a prescaler tick in the same cycle.
  function automatic logic op_blocks_tick(op_t op);
    return (op == OP_STOP) || (op == OP_CLEAR);
  endfunction

endpackage

// File: rtl/ctr_seq_if.sv
// Command port of the sequencer. A command transfers on any rising clk edge
// where cmd_valid && cmd_ready; the slave drops cmd_ready for one cycle after.
interface ctr_seq_if #(
  parameter int CTR_W = 32
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CTR_W-1:0] cmd_data;

  modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);
endinterface

// File: rtl/ctr_prescaler.sv
// Enable-gated prescaler: emits a tick every presc_div+1 enabled cycles.
module ctr_prescaler #(
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr,
  input  logic [PRESC_W-1:0] presc_div,
  output logic               tick,
  output logic [PRESC_W-1:0] presc_cnt
);

  assign tick = en && (presc_cnt == presc_div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt <= '0;
    end else if (clr || tick) begin
      presc_cnt <= '0;
    end else if (en) begin
      presc_cnt <= presc_cnt + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/ctr_sequencer.sv
// Command-driven counter sequencer: FSM, counter, limit compare and
// registered status outputs feeding the LED bank.
module ctr_sequencer
  import ctr_seq_pkg::*;
#(
  parameter int CTR_W   = CTR_W_DEF,
  parameter int PRESC_W = PRESC_W_DEF,
  parameter int OUT_W   = OUT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  ctr_seq_if.slave           cmd,
  input  logic               mode_periodic,
  input  logic [PRESC_W-1:0] presc_div,
  input  logic               ext_en,
  output logic [CTR_W-1:0]   count,
  output logic [OUT_W-1:0]   led_out,
  output logic [1:0]         state,
  output logic               done,
  output logic               cmd_err
);

  state_t             state_q, state_d;
  logic [CTR_W-1:0]   count_d;
  logic [CTR_W-1:0]   limit_q, limit_d;
  logic               done_d, err_d;
  logic               cmd_acc;
  op_t                op;
  logic               presc_en, presc_clr, tick;
  logic [PRESC_W-1:0] presc_cnt;

  assign cmd_acc = cmd.cmd_valid && cmd.cmd_ready;
  assign op      = op_t'(cmd.cmd_op);

  assign presc_en  = (state_q == ST_RUN) && ext_en && !(cmd_acc && op_blocks_tick(op));
  assign presc_clr = cmd_acc && ((op == OP_CLEAR) || (op == OP_START && state_q == ST_DONE));

  ctr_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (presc_en),
    .clr       (presc_clr),
    .presc_div (presc_div),
    .tick      (tick),
    .presc_cnt (presc_cnt)
  );

  always_comb begin
    state_d = state_q;
    count_d = count;
    limit_d = limit_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (cmd_acc) begin
      case (op)
        OP_START: begin
          if (state_q == ST_DONE) begin
            count_d = '0;
            state_d = ST_RUN;
          end else if (state_q != ST_RUN) begin
            state_d = ST_RUN;
          end
        end
        OP_STOP: begin
          if (state_q == ST_RUN) state_d = ST_PAUSE;
        end
        OP_CLEAR: begin
          count_d = '0;
          state_d = ST_IDLE;
        end
        OP_LOAD: begin
          if (state_q == ST_RUN) err_d = 1'b1;
          else                   limit_d = cmd.cmd_data;
        end
        default: ;
      endcase
    end

    // tick is already suppressed by STOP/CLEAR and only fires in RUN.
    if (tick) begin
      if (count == limit_q) begin
        done_d = 1'b1;
        if (mode_periodic) count_d = '0;
        else               state_d = ST_DONE;
      end else begin
        count_d = count + CTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      count         <= '0;
      limit_q       <= '1;
      done          <= 1'b0;
      cmd_err       <= 1'b0;
      cmd.cmd_ready <= 1'b1;
    end else begin
      state_q       <= state_d;
      count         <= count_d;
      limit_q       <= limit_d;
      done          <= done_d;
      cmd_err       <= err_d;
      cmd.cmd_ready <= !cmd_acc;
    end
  end

  assign state   = state_q;
  assign led_out = count[OUT_W-1:0];

endmodule

// File: tb/tb_ctr_sequencer.sv
// Randomized and directed bench for ctr_sequencer against a cycle-level
// behavioural model of the command/prescaler/terminal-count rules.
module tb_ctr_sequencer;

  localparam int CTR_W   = 32;
  localparam int PRESC_W = 16;
  localparam int OUT_W   = 22;

  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;
  localparam int C_START = 0, C_STOP = 1, C_CLEAR = 2, C_LOAD = 3;

  logic               clk;
  logic               rst_n;
  logic               mode_periodic;
  logic [PRESC_W-1:0] presc_div;
  logic               ext_en;
  logic [CTR_W-1:0]   count;
  logic [OUT_W-1:0]   led_out;
  logic [1:0]         state;
  logic               done;
  logic               cmd_err;

  ctr_seq_if #(.CTR_W(CTR_W)) cmd_bus ();

  ctr_sequencer #(.CTR_W(CTR_W), .PRESC_W(PRESC_W), .OUT_W(OUT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd           (cmd_bus),
    .mode_periodic (mode_periodic),
    .presc_div     (presc_div),
    .ext_en        (ext_en),
    .count         (count),
    .led_out       (led_out),
    .state         (state),
    .done          (done),
    .cmd_err       (cmd_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [CTR_W-1:0] exp_q[$];

  // reference model state
  int                 m_state;
  logic [CTR_W-1:0]   m_count, m_limit;
  logic [PRESC_W-1:0] m_presc;
  bit                 m_ready, m_done, m_err;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_state = S_IDLE;
    m_count = '0;
    m_limit = '1;
    m_presc = '0;
    m_ready = 1'b1;
    m_done  = 1'b0;
    m_err   = 1'b0;
    exp_q.delete();
  endtask

  // Applies one clock of the command/prescaler/terminal-count rules.
  task automatic model_step();
    bit acc, tick, blocked;
    int op;
    acc     = cmd_bus.cmd_valid && m_ready;
    op      = int'(cmd_bus.cmd_op);
    blocked = acc && (op == C_STOP || op == C_CLEAR);
    tick    = 1'b0;
    m_ready = !acc;
    m_done  = 1'b0;
    m_err   = 1'b0;
    if (m_state == S_RUN && ext_en && !blocked) begin
      if (m_presc == presc_div) begin
        tick = 1'b1;
        m_presc = '0;
      end else begin
        m_presc = m_presc + 1;
      end
    end
    // commands are judged against the state before this edge
    if (tick && m_count == m_limit && !mode_periodic) begin
      // handled below after command evaluation
    end
    begin
      int s0;
      s0 = m_state;
      if (acc) begin
        if (op == C_START) begin
          if (s0 == S_DONE) begin m_count = '0; m_presc = '0; m_state = S_RUN; end
          else if (s0 != S_RUN) m_state = S_RUN;
        end else if (op == C_STOP) begin
          if (s0 == S_RUN) m_state = S_PAUSE;
        end else if (op == C_CLEAR) begin
          m_count = '0; m_presc = '0; m_state = S_IDLE;
        end else begin
          if (s0 == S_RUN) m_err = 1'b1;
          else m_limit = cmd_bus.cmd_data;
        end
      end
    end
    if (tick) begin
      if (m_count == m_limit) begin
        m_done = 1'b1;
        if (mode_periodic) m_count = '0;
        else m_state = S_DONE;
      end else begin
        m_count = m_count + 1;
      end
    end
  endtask

  task automatic cycle();
    logic [CTR_W-1:0] e;
    model_step();
    exp_q.push_back(m_count);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("count", count, e);
    check("led_out", led_out, e[OUT_W-1:0]);
    check("state", state, m_state);
    check("done", done, m_done);
    check("cmd_err", cmd_err, m_err);
    check("cmd_ready", cmd_bus.cmd_ready, m_ready);
  endtask

  // driver: waits for the model to be ready, presents one command for a cycle
  task automatic do_cmd(input int op, input logic [CTR_W-1:0] data);
    int guard;
    guard = 0;
    while (!m_ready && guard < 4) begin
      cycle();
      guard++;
    end
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_op    = op[1:0];
    cmd_bus.cmd_data  = data;
    cycle();
    cmd_bus.cmd_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_count"}, count, 0);
    check({tag, "_state"}, state, S_IDLE);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, cmd_err, 0);
    check({tag, "_ready"}, cmd_bus.cmd_ready, 1);
    check({tag, "_led"}, led_out, 0);
  endtask

  initial begin
    int dones, guard;
    logic [CTR_W-1:0] held;

    rst_n = 1'b0;
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_op    = 2'd0;
    cmd_bus.cmd_data  = '0;
    mode_periodic = 1'b0;
    presc_div     = '0;
    ext_en        = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    rst_n = 1'b1;

    // one-shot to limit 5
    do_cmd(C_LOAD, 5);
    do_cmd(C_START, 0);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (done) dones++;
    end
    check("oneshot_dones", dones, 1);
    check("oneshot_state", state, S_DONE);
    check("oneshot_hold", count, 5);

    // START from DONE restarts at 0, CLEAR returns to IDLE
    do_cmd(C_START, 0);
    check("restart_count", count, 0);
    cycle();
    do_cmd(C_CLEAR, 0);
    check("clear_count", count, 0);
    check("clear_state", state, S_IDLE);

    // periodic, limit 3, presc_div 2: one done every 12 cycles
    mode_periodic = 1'b1;
    presc_div = 2;
    do_cmd(C_LOAD, 3);
    do_cmd(C_START, 0);
    dones = 0;
    for (int i = 0; i < 36; i++) begin
      cycle();
      if (done) dones++;
    end
    check("periodic_dones", dones, 3);

    // gated counting, pause and resume
    do_cmd(C_CLEAR, 0);
    presc_div = 0;
    mode_periodic = 1'b0;
    do_cmd(C_LOAD, 100);
    do_cmd(C_START, 0);
    for (int i = 0; i < 12; i++) begin
      ext_en = i[0];
      cycle();
    end
    ext_en = 1'b1;
    cycle();
    held = count;
    do_cmd(C_STOP, 0);
    check("stop_on_tick", count, held);
    check("pause_state", state, S_PAUSE);
    repeat (4) cycle();
    check("pause_hold", count, held);

    // LOAD_LIMIT rejected in RUN
    do_cmd(C_START, 0);
    do_cmd(C_LOAD, 2);
    cycle();
    check("load_in_run_err", cmd_err, 0);
    repeat (3) cycle();

    // randomized phase
    do_cmd(C_CLEAR, 0);
    for (int i = 0; i < 3000; i++) begin
      ext_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 40) == 0) mode_periodic = $urandom_range(0, 1);
      if (m_presc == 0 && $urandom_range(0, 30) == 0) presc_div = PRESC_W'($urandom_range(0, 3));
      cmd_bus.cmd_valid = ($urandom_range(0, 5) == 0);
      cmd_bus.cmd_op    = 2'($urandom_range(0, 3));
      cmd_bus.cmd_data  = CTR_W'($urandom_range(0, 15));
      cycle();
    end
    cmd_bus.cmd_valid = 1'b0;

    // asynchronous reset mid-run at count 1000
    do_cmd(C_CLEAR, 0);
    presc_div = 0;
    ext_en = 1'b1;
    mode_periodic = 1'b0;
    do_cmd(C_LOAD, 5000);
    do_cmd(C_START, 0);
    guard = 0;
    while (m_count != 1000 && guard < 3000) begin
      cycle();
      guard++;
    end
    check("reach_1000", count, 1000);
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    check_reset_vals("rst_held");
    rst_n = 1'b1;
    repeat (3) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
